// File: rtl/safecrack_pkg.sv
// Shared constants and types for the SafeCrack button path and the lock FSM.
package safecrack_pkg;

  localparam int N_BTN           = 3;
  localparam int CLK_HZ          = 50_000_000;
  // 20 ms settle window at the board clock
  localparam int DEBOUNCE_CYCLES = CLK_HZ / 50;
  localparam int BTN_W           = N_BTN;

  typedef logic [BTN_W-1:0] btn_vec_t;

endpackage

// File: rtl/safecrack_btn_cond_if.sv
// Button-conditioner bus: raw pins in, debounced levels and qualified press events out.
interface safecrack_btn_cond_if #(
  parameter int W = safecrack_pkg::BTN_W
);

  logic [W-1:0] btn_n;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_pulse;
  logic         press_valid;
  logic [W-1:0] press_code;
  logic         press_err;

  modport master (
    input  btn_n,
    output btn_level, btn_pulse, press_valid, press_code, press_err
  );

  modport slave (
    output btn_n,
    input  btn_level, btn_pulse, press_valid, press_code, press_err
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and press pulse.
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = safecrack_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_n_i,
  output logic level_o,
  output logic pulse_o
);
  import safecrack_pkg::*;

  localparam int              CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser keeps the raw (active-low) polarity so reset means "released".
  logic             meta_q, meta_d;
  logic             raw_q, raw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             sync;

  assign sync = ~raw_q;

  always_comb begin
    meta_d  = btn_n_i;
    raw_d   = meta_q;
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync != level_q) begin
      if (cnt_q == CNT_TC) begin
        level_d = ~level_q;
        pulse_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q  <= 1'b1;
      raw_q   <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      raw_q   <= raw_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/safecrack_btn_cond.sv
// SafeCrack input stage: per-button debounce plus single/overlapping press qualification.
module safecrack_btn_cond #(
  parameter int N_BTN           = safecrack_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = safecrack_pkg::DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rstn,
  safecrack_btn_cond_if.master bus
);
  import safecrack_pkg::*;

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] pulse;
  logic             one_hot;
  logic             others_idle;
  logic             valid;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rstn   (rstn),
      .btn_n_i(bus.btn_n[i]),
      .level_o(level[i]),
      .pulse_o(pulse[i])
    );
  end

  // A press is clean only if it is alone and no previously accepted button is still held.
  always_comb begin
    one_hot     = (pulse != '0) && ((pulse & (pulse - N_BTN'(1))) == '0);
    others_idle = ((level & ~pulse) == '0);
    valid       = one_hot && others_idle;
  end

  assign bus.btn_level   = level;
  assign bus.btn_pulse   = pulse;
  assign bus.press_valid = valid;
  assign bus.press_code  = valid ? pulse : '0;
  assign bus.press_err   = (pulse != '0) && !valid;

endmodule

// File: tb/tb_safecrack_btn_cond.sv
// Scoreboard bench for safecrack_btn_cond with a short debounce window.
module tb_safecrack_btn_cond;
  import safecrack_pkg::*;

  localparam int DC  = 8;
  localparam int LAT = DC + 2;

  typedef struct {
    int         cyc;
    logic [2:0] pulse;
    logic       valid;
    logic [2:0] code;
    logic       err;
  } ev_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   ecnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  sb[$];
  ev_t  mon_e;

  safecrack_btn_cond_if #(.W(3)) bus();

  safecrack_btn_cond #(
    .N_BTN(3),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.master)
  );

  always #10 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Every event the DUT emits must match the head of the scoreboard, cycle included.
  always @(negedge clk) begin
    if (rstn && (bus.btn_pulse != 3'b0 || bus.press_valid || bus.press_err || bus.press_code != 3'b0)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d pulse=%b valid=%b code=%b err=%b, required no event",
                 ecnt, bus.btn_pulse, bus.press_valid, bus.press_code, bus.press_err);
      end else begin
        mon_e = sb.pop_front();
        if (ecnt !== mon_e.cyc || bus.btn_pulse !== mon_e.pulse || bus.press_valid !== mon_e.valid ||
            bus.press_code !== mon_e.code || bus.press_err !== mon_e.err) begin
          n_bad++;
          $display("FAIL event got cyc=%0d pulse=%b valid=%b code=%b err=%b, required cyc=%0d pulse=%b valid=%b code=%b err=%b",
                   ecnt, bus.btn_pulse, bus.press_valid, bus.press_code, bus.press_err,
                   mon_e.cyc, mon_e.pulse, mon_e.valid, mon_e.code, mon_e.err);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int cyc, input logic [2:0] p, input logic v,
                         input logic [2:0] c, input logic e);
    ev_t x;
    x.cyc = cyc; x.pulse = p; x.valid = v; x.code = c; x.err = e;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.btn_n = 3'b111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.btn_level, bus.btn_pulse, bus.press_valid, bus.press_code, bus.press_err} !== 11'b0) begin
        n_bad++;
        $display("FAIL reset_hold outputs=%b required 0",
                 {bus.btn_level, bus.btn_pulse, bus.press_valid, bus.press_code, bus.press_err});
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.btn_level, bus.btn_pulse, bus.press_valid, bus.press_code, bus.press_err} !== 11'b0) begin
        n_bad++;
        $display("FAIL reset_idle outputs=%b required 0",
                 {bus.btn_level, bus.btn_pulse, bus.press_valid, bus.press_code, bus.press_err});
      end
    end
  endtask

  task automatic test_single_press();
    bus.btn_n[0] = 1'b0;
    push_ev(ecnt + LAT, 3'b001, 1'b1, 3'b001, 1'b0);
    step(LAT - 1);
    n_cmp++;
    if (bus.btn_level !== 3'b000) begin
      n_bad++; $display("FAIL single_level_early level=%b required 000", bus.btn_level);
    end
    step(1);
    n_cmp++;
    if (bus.btn_level !== 3'b001) begin
      n_bad++; $display("FAIL single_level_rise level=%b required 001", bus.btn_level);
    end
    step(20 - LAT);
    bus.btn_n[0] = 1'b1;
    step(LAT - 1);
    n_cmp++;
    if (bus.btn_level !== 3'b001) begin
      n_bad++; $display("FAIL single_release_early level=%b required 001", bus.btn_level);
    end
    step(1);
    n_cmp++;
    if (bus.btn_level !== 3'b000) begin
      n_bad++; $display("FAIL single_release_fall level=%b required 000", bus.btn_level);
    end
    step(10);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL single_drain pending=%0d required 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      bus.btn_n[1] = ~bus.btn_n[1];
      step(3);
      n_cmp++;
      if (bus.btn_level !== 3'b000) begin
        n_bad++; $display("FAIL bounce_level level=%b required 000", bus.btn_level);
      end
    end
    bus.btn_n[1] = 1'b0;
    push_ev(ecnt + LAT, 3'b010, 1'b1, 3'b010, 1'b0);
    step(20);
    bus.btn_n[1] = 1'b1;
    step(15);
    bus.btn_n[2] = 1'b0;
    step(7);
    bus.btn_n[2] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.btn_level !== 3'b000) begin
        n_bad++; $display("FAIL glitch_level level=%b required 000", bus.btn_level);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL bounce_drain pending=%0d required 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_simultaneous();
    bus.btn_n = 3'b010;
    push_ev(ecnt + LAT, 3'b101, 1'b0, 3'b000, 1'b1);
    step(15);
    n_cmp++;
    if (bus.btn_level !== 3'b101) begin
      n_bad++; $display("FAIL simul_level level=%b required 101", bus.btn_level);
    end
    bus.btn_n = 3'b111;
    step(15);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL simul_drain pending=%0d required 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_overlap();
    bus.btn_n = 3'b101;
    push_ev(ecnt + LAT, 3'b010, 1'b1, 3'b010, 1'b0);
    step(15);
    bus.btn_n = 3'b001;
    push_ev(ecnt + LAT, 3'b100, 1'b0, 3'b000, 1'b1);
    step(15);
    n_cmp++;
    if (bus.btn_level !== 3'b110) begin
      n_bad++; $display("FAIL overlap_level level=%b required 110", bus.btn_level);
    end
    bus.btn_n = 3'b111;
    step(15);
    bus.btn_n = 3'b011;
    push_ev(ecnt + LAT, 3'b100, 1'b1, 3'b100, 1'b0);
    step(15);
    bus.btn_n = 3'b111;
    step(15);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL overlap_drain pending=%0d required 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_release_press();
    bus.btn_n = 3'b110;
    push_ev(ecnt + LAT, 3'b001, 1'b1, 3'b001, 1'b0);
    step(15);
    bus.btn_n = 3'b101;
    push_ev(ecnt + LAT, 3'b010, 1'b1, 3'b010, 1'b0);
    step(LAT);
    n_cmp++;
    if (bus.btn_level !== 3'b010) begin
      n_bad++; $display("FAIL swap_level level=%b required 010", bus.btn_level);
    end
    step(5);
    bus.btn_n = 3'b111;
    step(15);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL swap_drain pending=%0d required 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    bus.btn_n = 3'b110;
    step(7);
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.btn_level, bus.btn_pulse, bus.press_valid, bus.press_code, bus.press_err} !== 11'b0) begin
        n_bad++;
        $display("FAIL midreset_hold outputs=%b required 0",
                 {bus.btn_level, bus.btn_pulse, bus.press_valid, bus.press_code, bus.press_err});
      end
    end
    rstn = 1'b1;
    push_ev(ecnt + LAT, 3'b001, 1'b1, 3'b001, 1'b0);
    step(LAT - 1);
    n_cmp++;
    if (bus.btn_level !== 3'b000) begin
      n_bad++; $display("FAIL midreset_early level=%b required 000", bus.btn_level);
    end
    step(1);
    n_cmp++;
    if (bus.btn_level !== 3'b001) begin
      n_bad++; $display("FAIL midreset_rise level=%b required 001", bus.btn_level);
    end
    step(10);
    bus.btn_n = 3'b111;
    step(15);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL midreset_drain pending=%0d required 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    bus.btn_n = 3'b111;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overlap();
    test_release_press();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
